// File: rtl/uart_pkg.sv
// Shared types and frame layout for the UART receive path.
// The frame is {stop, d7..d0, start} as delivered by the receiver shift register.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        CHECK
    } rxb_state_t;

    localparam int FRAME_W   = 10;
    localparam int START_BIT = 0;
    localparam int STOP_BIT  = 9;
    localparam int DATA_LSB  = 1;
    localparam int DATA_MSB  = 8;

    // A frame is well formed when the start bit is low and the stop bit is high.
    function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
        return (f[START_BIT] == 1'b0) && (f[STOP_BIT] == 1'b1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through FIFO; dout shows the head entry, zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // The pop frees a slot first, so push-while-full is legal alongside a pop.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Buffers completed UART frames: synchronises the receiver busy flag, checks the
// start/stop bits once per frame and queues the data byte, with sticky error flags.
module uart_rx_frame_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reading,
    input  logic [FRAME_W-1:0] frame,
    input  logic               pop,
    input  logic               clr_err,
    output logic [7:0]         data_out,
    output logic               empty,
    output logic               full,
    output logic [AW:0]        count,
    output logic               frame_err,
    output logic               overrun,
    output logic               frame_valid
);

    logic       rd_meta_reg;
    logic       rd_s_reg;
    rxb_state_t state_reg;
    rxb_state_t state_next;
    logic       fifo_push;
    logic       err_set;
    logic       ovr_set;
    logic       frame_err_reg;
    logic       overrun_reg;
    logic       frame_valid_reg;

    // reading may come from the divided receiver clock, so treat it as asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_meta_reg <= 1'b0;
            rd_s_reg    <= 1'b0;
        end else begin
            rd_meta_reg <= reading;
            rd_s_reg    <= rd_meta_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fifo_push  = 1'b0;
        err_set    = 1'b0;
        ovr_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_s_reg) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!rd_s_reg) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (!frame_ok(frame)) begin
                    err_set = 1'b1;
                end else if (!full || pop) begin
                    fifo_push = 1'b1;
                end else begin
                    ovr_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            frame_valid_reg <= fifo_push;
            if (err_set) begin
                frame_err_reg <= 1'b1;
            end else if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
            if (ovr_set) begin
                overrun_reg <= 1'b1;
            end else if (clr_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .din   (frame[DATA_MSB:DATA_LSB]),
        .dout  (data_out),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign frame_err   = frame_err_reg;
    assign overrun     = overrun_reg;
    assign frame_valid = frame_valid_reg;

endmodule
